// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system ID slave and
// checks the ID and build timestamp words against expected values.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1523851750,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        pass,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FIN
    } state_e;

    localparam bit          NO_LAT   = (READ_LATENCY == 0);
    localparam logic [1:0]  LAT_LAST =
        2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
    localparam logic [16:0] TMO_MAX  = 17'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  lat_q, lat_d;
    logic        auto_q;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        pass_q, pass_d;
    logic        tflag_q, tflag_d;

    logic accept, stall, tmo_hit, lat_last, go;

    assign accept   = avm_read & ~avm_waitrequest;
    assign stall    = avm_read & avm_waitrequest;
    assign tmo_hit  = stall && (({1'b0, tmo_q} + 17'd1) == TMO_MAX);
    assign lat_last = (lat_q == LAT_LAST);
    // auto_q is only set between reset release and the first edge
    assign go       = start | auto_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = RD_ID;
            RD_ID: begin
                if (accept)       state_d = NO_LAT ? RD_TS : LAT_ID;
                else if (tmo_hit) state_d = FIN;
            end
            LAT_ID:  if (lat_last) state_d = RD_TS;
            RD_TS: begin
                if (accept)       state_d = NO_LAT ? CHECK : LAT_TS;
                else if (tmo_hit) state_d = FIN;
            end
            LAT_TS:  if (lat_last) state_d = CHECK;
            CHECK:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            RD_ID:   avm_read = 1'b1;
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
            end
            LAT_TS:  avm_address = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        id_d    = id_q;
        ts_d    = ts_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        pass_d  = pass_q;
        tflag_d = tflag_q;
        tmo_d   = stall ? tmo_q + 16'd1 : 16'd0;
        lat_d   = 2'd0;
        if ((state_q == LAT_ID || state_q == LAT_TS) && !lat_last) begin
            lat_d = lat_q + 2'd1;
        end
        case (state_q)
            IDLE: begin
                if (go) begin
                    id_d    = 32'd0;
                    ts_d    = 32'd0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    pass_d  = 1'b0;
                    tflag_d = 1'b0;
                end
            end
            RD_ID: begin
                if (accept && NO_LAT) id_d = avm_readdata;
                if (tmo_hit)          tflag_d = 1'b1;
            end
            LAT_ID:  if (lat_last) id_d = avm_readdata;
            RD_TS: begin
                if (accept && NO_LAT) ts_d = avm_readdata;
                if (tmo_hit)          tflag_d = 1'b1;
            end
            LAT_TS:  if (lat_last) ts_d = avm_readdata;
            CHECK: begin
                id_ok_d = (id_q == EXPECTED_ID);
                ts_ok_d = (ts_q == EXPECTED_TIMESTAMP);
                pass_d  = (id_q == EXPECTED_ID) &&
                          (ts_q == EXPECTED_TIMESTAMP) && !tflag_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q   <= 16'd0;
            lat_q   <= 2'd0;
            auto_q  <= AUTO_START;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            pass_q  <= 1'b0;
            tflag_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            lat_q   <= lat_d;
            auto_q  <= 1'b0;
            id_q    <= id_d;
            ts_q    <= ts_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            pass_q  <= pass_d;
            tflag_q <= tflag_d;
        end
    end

    assign id_value = id_q;
    assign ts_value = ts_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign pass     = pass_q;
    assign timeout  = tflag_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: two checker instances (latency 0 with auto start,
// latency 2 without) against behavioural system ID slaves.
module tb_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1523851750;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst   [2];
    logic        start [2];
    logic        addr  [2];
    logic        rd    [2];
    logic [31:0] rdata [2];
    logic        wreq  [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] idv   [2];
    logic [31:0] tsv   [2];
    logic        idok  [2];
    logic        tsok  [2];
    logic        pass  [2];
    logic        tmo   [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [67:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    sysid_checker #(
        .READ_LATENCY(0), .TIMEOUT_CYCLES(5), .AUTO_START(1'b1)
    ) u_dut0 (
        .clock(clock), .reset(rst[0]), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]),
        .avm_readdata(rdata[0]), .avm_waitrequest(wreq[0]),
        .busy(busy[0]), .done(done[0]),
        .id_value(idv[0]), .ts_value(tsv[0]),
        .id_ok(idok[0]), .ts_ok(tsok[0]),
        .pass(pass[0]), .timeout(tmo[0])
    );

    sysid_checker #(
        .READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1'b0)
    ) u_dut1 (
        .clock(clock), .reset(rst[1]), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]),
        .avm_readdata(rdata[1]), .avm_waitrequest(wreq[1]),
        .busy(busy[1]), .done(done[1]),
        .id_value(idv[1]), .ts_value(tsv[1]),
        .id_ok(idok[1]), .ts_ok(tsok[1]),
        .pass(pass[1]), .timeout(tmo[1])
    );

    // Slave models
    int          stall_n [2];
    bit          hang    [2];
    bit          hang_ts [2];
    logic [31:0] mem_id  [2];
    logic [31:0] mem_ts  [2];
    int          scnt    [2];
    int          acc_cnt [2];
    logic [7:0]  acc_seq [2];
    logic        p1v, p1a, p2v, p2a;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                scnt[g] <= 0;
            end else if (rd[g] && wreq[g]) begin
                scnt[g] <= scnt[g] + 1;
            end else if (rd[g]) begin
                scnt[g]    <= 0;
                acc_cnt[g] <= acc_cnt[g] + 1;
                acc_seq[g] <= {acc_seq[g][6:0], addr[g]};
            end
        end
        p1v <= rd[1] && !wreq[1] && !rst[1];
        p1a <= addr[1];
        p2v <= p1v && !rst[1];
        p2a <= p1a;
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            wreq[g] = rd[g] && (hang[g] || (hang_ts[g] && addr[g]) ||
                                (scnt[g] < stall_n[g]));
        end
        rdata[0] = rd[0] ? (addr[0] ? mem_ts[0] : mem_id[0]) : 32'hDEADBEEF;
        rdata[1] = p2v ? (p2a ? mem_ts[1] : mem_id[1]) : 32'hDEADBEEF;
    end

    // Output monitors
    int   done_cnt [2];
    int   rd_cyc   [2];
    int   addr_err [2];
    logic prev_stall [2];
    logic prev_addr  [2];

    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (done[g] === 1'b1) done_cnt[g]++;
            if (rd[g] === 1'b1) rd_cyc[g]++;
            if (prev_stall[g] === 1'b1 && rd[g] === 1'b1 &&
                addr[g] !== prev_addr[g]) addr_err[g]++;
            prev_stall[g] = rd[g] && wreq[g];
            prev_addr[g]  = addr[g];
        end
    end

    function automatic logic [67:0] obs(input int d);
        return {idv[d], tsv[d], idok[d], tsok[d], pass[d], tmo[d]};
    endfunction

    function automatic logic [71:0] outs(input int d);
        return {rd[d], addr[d], busy[d], done[d], obs(d)};
    endfunction

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] t,
                                input logic a, input logic b,
                                input logic c, input logic e, input int lat);
        exp_t x;
        x.res = {i, t, a, b, c, e};
        x.lat = lat;
        return x;
    endfunction

    task automatic pulse_start(input int d, output int c0);
        @(negedge clock);
        start[d] = 1'b1;
        c0 = cyc;
        @(negedge clock);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done[d] === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int r1;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (outs(d) !== 72'd0) begin
                n_bad++;
                $display("FAIL reset_outs%0d: got %h want 0", d, outs(d));
            end
        end
        r1 = rd_cyc[1];
        rst[1] = 1'b0;
        repeat (6) @(negedge clock);
        n_cmp++;
        if (busy[1] !== 1'b0 || rd_cyc[1] != r1) begin
            n_bad++;
            $display("FAIL no_autostart: busy %b reads %0d want 0/0",
                     busy[1], rd_cyc[1] - r1);
        end
    endtask

    task automatic test_auto_start();
        int c0, at, d0;
        exp_t e;
        d0 = done_cnt[0];
        @(negedge clock);
        rst[0] = 1'b0;
        c0 = cyc;
        sb.push_back(mk(32'd0, TS_GOOD, 1, 1, 1, 0, 4));
        @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        wait_done(0, at);
        e = sb.pop_front();
        n_cmp++;
        if (at - c0 != e.lat) begin
            n_bad++;
            $display("FAIL auto_lat: got %0d want %0d", at - c0, e.lat);
        end
        n_cmp++;
        if (obs(0) !== e.res) begin
            n_bad++;
            $display("FAIL auto_res: got %h want %h", obs(0), e.res);
        end
        repeat (8) @(negedge clock);
        n_cmp++;
        if (done_cnt[0] - d0 != 1) begin
            n_bad++;
            $display("FAIL auto_once: got %0d dones want 1", done_cnt[0] - d0);
        end
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_busy: got %b want 0", busy[0]);
        end
    endtask

    task automatic test_basic();
        int c0, at, a0, r0;
        exp_t e;
        a0 = acc_cnt[0];
        r0 = rd_cyc[0];
        pulse_start(0, c0);
        sb.push_back(mk(32'd0, TS_GOOD, 1, 1, 1, 0, 4));
        wait_done(0, at);
        e = sb.pop_front();
        n_cmp++;
        if (at - c0 != e.lat) begin
            n_bad++;
            $display("FAIL basic_lat: got %0d want %0d", at - c0, e.lat);
        end
        n_cmp++;
        if (obs(0) !== e.res) begin
            n_bad++;
            $display("FAIL basic_res: got %h want %h", obs(0), e.res);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (acc_cnt[0] - a0 != 2 || acc_seq[0][1:0] !== 2'b01) begin
            n_bad++;
            $display("FAIL basic_reads: got %0d seq %b want 2 seq 01",
                     acc_cnt[0] - a0, acc_seq[0][1:0]);
        end
        n_cmp++;
        if (rd_cyc[0] - r0 != 2) begin
            n_bad++;
            $display("FAIL basic_rdcyc: got %0d want 2", rd_cyc[0] - r0);
        end
    endtask

    task automatic test_ts_mismatch();
        int c0, at;
        exp_t e;
        mem_ts[0] = TS_GOOD + 32'd1;
        pulse_start(0, c0);
        sb.push_back(mk(32'd0, TS_GOOD + 32'd1, 1, 0, 0, 0, 4));
        wait_done(0, at);
        e = sb.pop_front();
        n_cmp++;
        if (at - c0 != e.lat) begin
            n_bad++;
            $display("FAIL tsbad_lat: got %0d want %0d", at - c0, e.lat);
        end
        n_cmp++;
        if (obs(0) !== e.res) begin
            n_bad++;
            $display("FAIL tsbad_res: got %h want %h", obs(0), e.res);
        end
        repeat (2) @(negedge clock);
        mem_ts[0] = TS_GOOD;
    endtask

    task automatic test_stall_latency();
        int c0, at, a0, e0;
        exp_t e;
        stall_n[1] = 3;
        a0 = acc_cnt[1];
        e0 = addr_err[1];
        pulse_start(1, c0);
        sb.push_back(mk(32'd0, TS_GOOD, 1, 1, 1, 0, 14));
        wait_done(1, at);
        e = sb.pop_front();
        n_cmp++;
        if (at - c0 != e.lat) begin
            n_bad++;
            $display("FAIL stall_lat: got %0d want %0d", at - c0, e.lat);
        end
        n_cmp++;
        if (obs(1) !== e.res) begin
            n_bad++;
            $display("FAIL stall_res: got %h want %h", obs(1), e.res);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (addr_err[1] != e0) begin
            n_bad++;
            $display("FAIL stall_addr: got %0d changes want 0", addr_err[1] - e0);
        end
        n_cmp++;
        if (acc_cnt[1] - a0 != 2) begin
            n_bad++;
            $display("FAIL stall_reads: got %0d want 2", acc_cnt[1] - a0);
        end
        stall_n[1] = 0;
    endtask

    task automatic test_timeout(input bit on_ts);
        int c0, at, d0, r0;
        exp_t e;
        if (on_ts) begin
            hang_ts[0] = 1'b1;
            mem_id[0]  = 32'h0000_1234;
            sb.push_back(mk(32'h0000_1234, 32'd0, 0, 0, 0, 1, 7));
        end else begin
            hang[0] = 1'b1;
            sb.push_back(mk(32'd0, 32'd0, 0, 0, 0, 1, 6));
        end
        d0 = done_cnt[0];
        r0 = rd_cyc[0];
        pulse_start(0, c0);
        wait_done(0, at);
        e = sb.pop_front();
        n_cmp++;
        if (at - c0 != e.lat) begin
            n_bad++;
            $display("FAIL tmo%0d_lat: got %0d want %0d", on_ts, at - c0, e.lat);
        end
        n_cmp++;
        if (obs(0) !== e.res) begin
            n_bad++;
            $display("FAIL tmo%0d_res: got %h want %h", on_ts, obs(0), e.res);
        end
        repeat (4) @(negedge clock);
        n_cmp++;
        if (rd_cyc[0] - r0 != (on_ts ? 6 : 5)) begin
            n_bad++;
            $display("FAIL tmo%0d_rdcyc: got %0d want %0d", on_ts,
                     rd_cyc[0] - r0, on_ts ? 6 : 5);
        end
        n_cmp++;
        if (done_cnt[0] - d0 != 1 || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo%0d_end: got %0d dones busy %b want 1/0", on_ts,
                     done_cnt[0] - d0, busy[0]);
        end
        hang[0]    = 1'b0;
        hang_ts[0] = 1'b0;
        mem_id[0]  = 32'd0;
    endtask

    task automatic test_reset_mid_read();
        int c0, at;
        bit found;
        exp_t e;
        stall_n[0] = 4;
        found = 1'b0;
        pulse_start(0, c0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rd[0] === 1'b1 && addr[0] === 1'b1 && wreq[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL midrst_find: got no RD_TS stall want one");
        end
        #2 rst[0] = 1'b1;
        #1;
        n_cmp++;
        if (outs(0) !== 72'd0) begin
            n_bad++;
            $display("FAIL midrst_async: got %h want 0", outs(0));
        end
        repeat (2) @(negedge clock);
        rst[0] = 1'b0;
        c0 = cyc;
        sb.push_back(mk(32'd0, TS_GOOD, 1, 1, 1, 0, 12));
        wait_done(0, at);
        e = sb.pop_front();
        n_cmp++;
        if (at - c0 != e.lat) begin
            n_bad++;
            $display("FAIL midrst_lat: got %0d want %0d", at - c0, e.lat);
        end
        n_cmp++;
        if (obs(0) !== e.res) begin
            n_bad++;
            $display("FAIL midrst_res: got %h want %h", obs(0), e.res);
        end
        repeat (3) @(negedge clock);
        stall_n[0] = 0;
    endtask

    initial begin
        rst[0]   = 1'b1;
        rst[1]   = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            stall_n[g] = 0;
            hang[g]    = 1'b0;
            hang_ts[g] = 1'b0;
            mem_id[g]  = 32'd0;
            mem_ts[g]  = TS_GOOD;
        end
        test_reset();
        test_auto_start();
        test_basic();
        test_ts_mismatch();
        test_stall_latency();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
